// File: rtl/pipe_ctrl_pkg.sv
// Shared state encodings and command bundle for the pipeline sequencing controller.
// The resolver gives flush (or PC load) precedence over stall on the same target.
package pipe_ctrl_pkg;

  localparam int STATE_W = 3;

  localparam logic [STATE_W-1:0] PCTL_RUN     = 3'd0;
  localparam logic [STATE_W-1:0] PCTL_EX_WAIT = 3'd1;
  localparam logic [STATE_W-1:0] PCTL_DRAIN   = 3'd2;
  localparam logic [STATE_W-1:0] PCTL_HELD    = 3'd3;
  localparam logic [STATE_W-1:0] PCTL_ABORT   = 3'd4;

  typedef struct packed {
    logic pc_load;
    logic pc_stall;
    logic if_id_stall;
    logic if_id_flush;
    logic id_ex_stall;
    logic id_ex_flush;
  } pctl_cmd_t;

  function automatic pctl_cmd_t resolve_cmd(input pctl_cmd_t raw);
    pctl_cmd_t res;
    res             = raw;
    res.pc_stall    = raw.pc_stall    & ~raw.pc_load;
    res.if_id_stall = raw.if_id_stall & ~raw.if_id_flush;
    res.id_ex_stall = raw.id_ex_stall & ~raw.id_ex_flush;
    return res;
  endfunction

endpackage

// File: rtl/pipe_ctrl_stall_timer.sv
// Consecutive-stall counter for the EX watchdog; saturates instead of wrapping.
// expired flags the last permitted stall cycle (cnt == STALL_TIMEOUT-1).
module stall_timer #(
  parameter int STALL_TIMEOUT = 64,
  localparam int CNT_W = $clog2(STALL_TIMEOUT) + 1
) (
  input  logic sys_clk,
  input  logic sys_rst,
  input  logic clear,
  input  logic start,
  input  logic incr,
  output logic expired
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (start) begin
      cnt <= CNT_W'(1);
    end else if (incr && (cnt != {CNT_W{1'b1}})) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign expired = (cnt == CNT_W'(STALL_TIMEOUT - 1));

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline sequencing controller: turns redirects, EX stalls and bus holds into
// PC and IF/ID, ID/EX stall/flush commands, with a watchdog bounding EX stalls.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int STALL_TIMEOUT = 64
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        jump_en,
  input  logic [31:0] jump_addr,
  input  logic        ex_stall_req,
  input  logic        bus_hold_req,
  output logic        pc_load,
  output logic [31:0] pc_load_addr,
  output logic        pc_stall,
  output logic        if_id_stall,
  output logic        if_id_flush,
  output logic        id_ex_stall,
  output logic        id_ex_flush,
  output logic        bus_hold_ack,
  output logic        stall_err
);

  logic [STATE_W-1:0] state, next_state;
  pctl_cmd_t          raw_cmd, cmd;
  logic               tmr_clear, tmr_start, tmr_incr, tmr_expired, err_set;

  localparam pctl_cmd_t CMD_JUMP  = '{pc_load: 1'b1, if_id_flush: 1'b1, id_ex_flush: 1'b1, default: 1'b0};
  localparam pctl_cmd_t CMD_STALL = '{pc_stall: 1'b1, if_id_stall: 1'b1, id_ex_stall: 1'b1, default: 1'b0};
  // Front end frozen while a bubble is pushed into EX so the EX instruction retires.
  localparam pctl_cmd_t CMD_DRAIN = '{pc_stall: 1'b1, if_id_stall: 1'b1, id_ex_flush: 1'b1, default: 1'b0};

  always_comb begin
    next_state = state;
    raw_cmd    = '0;
    tmr_start  = 1'b0;
    tmr_incr   = 1'b0;
    err_set    = 1'b0;
    case (state)
      PCTL_RUN: begin
        if (jump_en) begin
          raw_cmd    = CMD_JUMP;
          next_state = bus_hold_req ? PCTL_DRAIN : PCTL_RUN;
        end else if (ex_stall_req) begin
          raw_cmd    = CMD_STALL;
          tmr_start  = 1'b1;
          next_state = PCTL_EX_WAIT;
        end else if (bus_hold_req) begin
          next_state = PCTL_DRAIN;
        end
      end
      PCTL_EX_WAIT: begin
        if (ex_stall_req) begin
          raw_cmd = CMD_STALL;
          if (tmr_expired) begin
            err_set    = 1'b1;
            next_state = PCTL_ABORT;
          end else begin
            tmr_incr = 1'b1;
          end
        end else begin
          next_state = bus_hold_req ? PCTL_DRAIN : PCTL_RUN;
        end
      end
      PCTL_DRAIN: begin
        if (jump_en) begin
          raw_cmd    = CMD_JUMP;
          next_state = bus_hold_req ? PCTL_HELD : PCTL_RUN;
        end else if (ex_stall_req) begin
          raw_cmd    = CMD_STALL;
          tmr_start  = 1'b1;
          next_state = PCTL_EX_WAIT;
        end else begin
          raw_cmd    = CMD_DRAIN;
          next_state = bus_hold_req ? PCTL_HELD : PCTL_RUN;
        end
      end
      PCTL_HELD: begin
        raw_cmd = CMD_DRAIN;
        if (!bus_hold_req) next_state = PCTL_RUN;
      end
      PCTL_ABORT: begin
        if (!ex_stall_req) next_state = PCTL_RUN;
      end
      default: next_state = PCTL_RUN;
    endcase
  end

  assign tmr_clear = (next_state == PCTL_RUN);
  assign cmd       = resolve_cmd(raw_cmd);

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state        <= PCTL_RUN;
      bus_hold_ack <= 1'b0;
      stall_err    <= 1'b0;
    end else begin
      state        <= next_state;
      bus_hold_ack <= (next_state == PCTL_HELD);
      stall_err    <= err_set;
    end
  end

  stall_timer #(
    .STALL_TIMEOUT(STALL_TIMEOUT)
  ) u_stall_timer (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .clear   (tmr_clear),
    .start   (tmr_start),
    .incr    (tmr_incr),
    .expired (tmr_expired)
  );

  assign pc_load      = cmd.pc_load;
  assign pc_load_addr = cmd.pc_load ? jump_addr : 32'd0;
  assign pc_stall     = cmd.pc_stall;
  assign if_id_stall  = cmd.if_id_stall;
  assign if_id_flush  = cmd.if_id_flush;
  assign id_ex_stall  = cmd.id_ex_stall;
  assign id_ex_flush  = cmd.id_ex_flush;

endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Pipeline sequencing controller for the 3-stage IF/ID/EX core. It turns EX-stage redirect requests, multi-cycle EX stall requests and external pipeline-hold requests into PC load/stall commands and per-register stall/flush commands for the IF/ID and ID/EX pipeline registers. It also bounds EX stalls with a watchdog.

## Interface
Parameters:
- STALL_TIMEOUT, 64: maximum consecutive cycles stall outputs stay asserted for one EX stall request. Must be ≥2.

Ports:
- sys_clk  input  1  core clock; all state updates on the rising edge.
- sys_rst  input  1  reset, asynchronous, active-high.
- jump_en  input  1  EX-stage branch/jump taken, valid in the same cycle.
- jump_addr  input  32  redirect target, valid when jump_en=1.
- ex_stall_req  input  1  level request from a multi-cycle EX unit (divider); high while busy.
- bus_hold_req  input  1  level request from the debug/bus master to quiesce the pipeline.
- pc_load  output  1  PC loads pc_load_addr this edge.
- pc_load_addr  output  32  equals jump_addr when pc_load=1, 0 otherwise.
- pc_stall  output  1  PC holds its value.
- if_id_stall  output  1  IF/ID register holds contents.
- if_id_flush  output  1  IF/ID register loads NOP.
- id_ex_stall  output  1  ID/EX register holds contents.
- id_ex_flush  output  1  ID/EX register loads NOP (drives its hold_en).
- bus_hold_ack  output  1  pipeline quiescent; registered.
- stall_err  output  1  one-cycle pulse on watchdog abort; registered.

## Operation
- The FSM has five states: RUN, EX_WAIT, DRAIN, HELD, ABORT. Encodings are 3 bits.
- Command outputs are combinational from state and inputs. Flush takes priority over stall on the same register.
- RUN:
  - When jump_en=1, assert pc_load, if_id_flush and id_ex_flush. Jump wins over a simultaneous ex_stall_req, which is ignored that cycle.
  - Otherwise, when ex_stall_req=1, assert pc_stall, if_id_stall and id_ex_stall, set cnt←1, and go to EX_WAIT.
  - Otherwise, when bus_hold_req=1, go to DRAIN with no outputs this cycle.
  - When jump_en and bus_hold_req are both high, perform the jump and go to DRAIN.
- EX_WAIT:
  - While ex_stall_req=1, assert all three stalls.
  - When cnt==STALL_TIMEOUT-1, go to ABORT and set stall_err←1. Otherwise cnt←cnt+1.
  - When ex_stall_req=0, all outputs are 0, and the next state is DRAIN if bus_hold_req=1, else RUN.
  - jump_en is ignored.
- DRAIN:
  - Assert pc_stall, if_id_stall and id_ex_flush. The EX instruction completes while a bubble enters EX.
  - jump_en=1 overrides this: assert pc_load, if_id_flush and id_ex_flush.
  - ex_stall_req=1 overrides this: assert all three stalls, cnt←1, go to EX_WAIT.
  - When bus_hold_req=0, go to RUN.
  - Otherwise go to HELD.
- HELD:
  - Assert pc_stall, if_id_stall and id_ex_flush. bus_hold_ack=1 while in this state.
  - When bus_hold_req=0, go to RUN. jump_en and ex_stall_req are ignored.
- ABORT:
  - All command outputs are 0 and the pipeline advances.
  - Stay in ABORT until ex_stall_req=0, then go to RUN.
  - stall_err is high only in the first ABORT cycle.
- cnt is $clog2(STALL_TIMEOUT)+1 bits wide, unsigned, and never wraps. It is cleared on every entry to RUN.

## Timing
- Reset values: state=RUN, cnt=0, bus_hold_ack=0, stall_err=0. With inputs low, all combinational outputs are 0.
- Redirect has 0-cycle latency: pc_load and both flushes appear in the same cycle as jump_en.
- Stalls assert in the same cycle ex_stall_req rises and drop in the same cycle it falls.
- The maximum stall run is STALL_TIMEOUT cycles. The stall outputs are 0 in the cycle after the last stall cycle.
- Bus hold timing:
  - bus_hold_req seen in RUN at cycle t gives DRAIN at t+1, HELD at t+2, and bus_hold_ack=1 from t+2.
  - When bus_hold_req drops at cycle u in HELD, ack=0 and the outputs release at u+1.
- Reset asserted mid-operation forces RUN immediately and clears ack, err and cnt. Outputs follow the RUN rules.

## Structure
- State encodings (`PCTL_RUN` … `PCTL_ABORT`) are added to defines.v alongside `INST_NOP`.
- One sub-module, stall_timer, holds cnt with clear/increment/expired signals and is parameterised by STALL_TIMEOUT.
- if_id and id_ex gain a stall input. Their existing hold_en is driven by the *_flush outputs.

## Test plan
- Jump: jump_en=1 with jump_addr=0x0000_0100 in RUN → same cycle pc_load=1, pc_load_addr=0x100, if_id_flush=1, id_ex_flush=1; next cycle all 0.
- Divide stall: ex_stall_req high for 5 cycles → pc_stall, if_id_stall and id_ex_stall high for exactly those 5 cycles, then 0; stall_err never pulses.
- Watchdog (STALL_TIMEOUT=8): ex_stall_req held for 20 cycles → stalls high for cycles 1–8, stall_err=1 in cycle 9 only, stalls 0 from cycle 9; RUN resumes after the request drops.
- Bus hold: bus_hold_req rises at t → DRAIN at t+1 (id_ex_flush=1), bus_hold_ack=1 from t+2; request drops at u → ack=0 and outputs 0 at u+1.
- Collisions:
  - jump_en with ex_stall_req in RUN → jump performed, no stall, state stays RUN.
  - ex_stall_req in DRAIN → EX_WAIT; after release with bus_hold_req still high → DRAIN → HELD.
- Reset mid-HELD: sys_rst pulse → bus_hold_ack=0 immediately, state RUN, cnt=0.
